// File: rtl/ttl_gen_axil_regs.sv
// ---------------------------------------------------------------------------
// ttl_gen_axil_regs
//
// AXI4-Lite responder holding the TTL pulse generator registers, plus the
// generator itself.
//
// Register map (decoded on ADDR[3:2], ADDR[1:0] ignored):
//   0x0 CTRL   RW  bit0 EN, bit1 INV, upper bits read 0
//   0x4 PERIOD RW  period in ACLK cycles
//   0x8 WIDTH  RW  high time in ACLK cycles
//   0xC COUNT  RO  periods started (wraps); writes return SLVERR
//
// Ports:
//   ACLK, ARESET           clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W*   write address / data channels (accepted together)
//   S_AXI_B*               write response
//   S_AXI_AR* / S_AXI_R*   read address / data channels
//   TTL_OUT                registered pulse output
// ---------------------------------------------------------------------------
module ttl_gen_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            TTL_OUT
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_WIDTH  = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [DW-1:0] apply_wstrb(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Bus-side state
    logic          aw_ready_q;
    logic          b_valid_q;
    logic [1:0]    b_resp_q;
    logic          ar_ready_q;
    logic          r_valid_q;
    logic [DW-1:0] r_data_q;

    // Registers and generator state
    logic [1:0]    ctrl_q;
    logic [DW-1:0] period_q;
    logic [DW-1:0] width_q;
    logic [DW-1:0] count_q;
    logic [DW-1:0] cnt_q;
    logic          ttl_q;

    logic          wr_accept;
    logic          rd_accept;
    logic [1:0]    wr_sel;
    logic [1:0]    rd_sel;
    logic [DW-1:0] wr_old;
    logic [DW-1:0] wr_merged;
    logic [DW-1:0] rd_mux;
    logic          gen_run;
    logic          cnt_wrap;
    logic          pulse_raw;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_sel    = S_AXI_AWADDR[3:2];
    assign rd_sel    = S_AXI_ARADDR[3:2];
    // AWREADY/WREADY are a shared one-cycle pulse, so one term covers both.
    assign wr_accept = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_accept = ar_ready_q & S_AXI_ARVALID;

    always_comb begin
        wr_old = '0;
        case (wr_sel)
            REG_CTRL:   wr_old = {{(DW-2){1'b0}}, ctrl_q};
            REG_PERIOD: wr_old = period_q;
            REG_WIDTH:  wr_old = width_q;
            default:    wr_old = count_q;
        endcase
        wr_merged = apply_wstrb(wr_old, S_AXI_WDATA, S_AXI_WSTRB);
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            REG_CTRL:   rd_mux = {{(DW-2){1'b0}}, ctrl_q};
            REG_PERIOD: rd_mux = period_q;
            REG_WIDTH:  rd_mux = width_q;
            default:    rd_mux = count_q;
        endcase
    end

    // Write channel. Ready is registered and self-clearing so it is a single
    // pulse; it may rise on the edge that retires the previous response, which
    // gives two-cycle back-to-back writes when BREADY is held high.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            aw_ready_q <= ~aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID
                          & (~b_valid_q | S_AXI_BREADY);
            if (wr_accept) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= (wr_sel == REG_COUNT) ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_BREADY) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // Register file. COUNT is not writable from the bus.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ctrl_q   <= '0;
            period_q <= '0;
            width_q  <= '0;
        end else if (wr_accept) begin
            case (wr_sel)
                REG_CTRL:   ctrl_q   <= wr_merged[1:0];
                REG_PERIOD: period_q <= wr_merged;
                REG_WIDTH:  width_q  <= wr_merged;
                default:    ;
            endcase
        end
    end

    // Read channel. RDATA is captured at accept, so a same-cycle write to the
    // same register is not visible in this read.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            ar_ready_q <= ~ar_ready_q & S_AXI_ARVALID & (~r_valid_q | S_AXI_RREADY);
            if (rd_accept) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    // Generator. Using >= for the wrap test means a PERIOD rewritten below the
    // running count wraps immediately instead of counting through 2^32.
    assign gen_run   = ctrl_q[0] & (period_q != '0);
    assign cnt_wrap  = (cnt_q >= period_q - 1'b1);
    assign pulse_raw = gen_run & (cnt_q < width_q);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q   <= '0;
            count_q <= '0;
            ttl_q   <= 1'b0;
        end else begin
            if (!gen_run || cnt_wrap) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (gen_run && (cnt_q == '0)) begin
                count_q <= count_q + 1'b1;
            end
            ttl_q <= pulse_raw ^ ctrl_q[1];
        end
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_BRESP   = b_resp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign TTL_OUT       = ttl_q;

endmodule

// File: tb/tb_ttl_gen_axil_regs.sv
// ---------------------------------------------------------------------------
// tb_ttl_gen_axil_regs
//
// Drives directed and $urandom AXI4-Lite traffic into ttl_gen_axil_regs and
// compares bus responses and TTL_OUT against a behavioural model of the
// register map and pulse generator kept in this file.
// ---------------------------------------------------------------------------
module tb_ttl_gen_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        TTL_OUT;

    always #5 ACLK = ~ACLK;

    ttl_gen_axil_regs dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .TTL_OUT       (TTL_OUT)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_ctrl, m_period, m_width, m_count;
    logic [31:0] m_phase;     // cycles into the current period
    logic        m_ttl;
    logic [31:0] m_rdata;
    logic [1:0]  m_bresp;
    logic        m_run;
    bit          ttl_chk = 0;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] reg_view(input logic [1:0] idx);
        case (idx)
            2'd0:    return m_ctrl;
            2'd1:    return m_period;
            2'd2:    return m_width;
            default: return m_count;
        endcase
    endfunction

    always @(posedge ACLK) begin
        if (ARESET) begin
            m_ctrl = 0; m_period = 0; m_width = 0; m_count = 0;
            m_phase = 0; m_ttl = 0; m_rdata = 0; m_bresp = 0;
        end else begin
            if (S_AXI_ARVALID && S_AXI_ARREADY) m_rdata = reg_view(S_AXI_ARADDR[3:2]);
            m_run = m_ctrl[0] && (m_period != 0);
            m_ttl = (m_run && (m_phase < m_width)) ^ m_ctrl[1];
            if (m_run && m_phase == 0) m_count = m_count + 1;
            if (!m_run || (longint'(m_phase) + 1 >= longint'(m_period))) m_phase = 0;
            else m_phase = m_phase + 1;
            if (S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_WVALID && S_AXI_WREADY) begin
                case (S_AXI_AWADDR[3:2])
                    2'd0: m_ctrl   = merge_bytes(m_ctrl, S_AXI_WDATA, S_AXI_WSTRB) & 32'h3;
                    2'd1: m_period = merge_bytes(m_period, S_AXI_WDATA, S_AXI_WSTRB);
                    2'd2: m_width  = merge_bytes(m_width, S_AXI_WDATA, S_AXI_WSTRB);
                    default: ;
                endcase
                m_bresp = (S_AXI_AWADDR[3:2] == 2'd3) ? 2'b10 : 2'b00;
            end
        end
    end

    always @(negedge ACLK) begin
        if (ttl_chk) check_val("ttl", 32'(TTL_OUT), 32'(m_ttl));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus tasks (called and returning at a negedge) ----------------
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_lead, input int b_hold);
        int n;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        for (int i = 0; i < aw_lead; i++) begin
            @(negedge ACLK);
            check_val("aw_alone_wait", 32'(S_AXI_AWREADY), 32'd0);
        end
        S_AXI_WVALID = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!S_AXI_AWREADY && n < 50);
        check_val("wr_accept", 32'(S_AXI_AWREADY), 32'd1);
        check_val("wready", 32'(S_AXI_WREADY), 32'd1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check_val("awready_pulse", 32'(S_AXI_AWREADY), 32'd0);
        check_val("bvalid", 32'(S_AXI_BVALID), 32'd1);
        check_val("bresp", 32'(S_AXI_BRESP), 32'(m_bresp));
        if (b_hold < 0) return;
        for (int i = 0; i < b_hold; i++) begin
            @(negedge ACLK);
            check_val("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            check_val("bresp_hold", 32'(S_AXI_BRESP), 32'(m_bresp));
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check_val("bvalid_clr", 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!S_AXI_ARREADY && n < 50);
        check_val("rd_accept", 32'(S_AXI_ARREADY), 32'd1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        check_val("arready_pulse", 32'(S_AXI_ARREADY), 32'd0);
        check_val("rvalid", 32'(S_AXI_RVALID), 32'd1);
        check_val("rdata", S_AXI_RDATA, m_rdata);
        check_val("rresp", 32'(S_AXI_RRESP), 32'd0);
        data = S_AXI_RDATA;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        check_val("rvalid_clr", 32'(S_AXI_RVALID), 32'd0);
    endtask

    // Write and read presented together so both are accepted on one edge.
    task automatic axi_wr_rd_same(input logic [3:0] addr, input logic [31:0] data,
                                  output logic [31:0] rd);
        int n;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = addr;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!S_AXI_AWREADY && n < 50);
        check_val("same_aw_accept", 32'(S_AXI_AWREADY), 32'd1);
        check_val("same_ar_accept", 32'(S_AXI_ARREADY), 32'd1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check_val("same_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check_val("same_bresp_slverr", 32'(S_AXI_BRESP), 32'd2);
        check_val("same_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check_val("same_rdata_old", S_AXI_RDATA, m_rdata);
        rd = S_AXI_RDATA;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        check_val("same_bvalid_clr", 32'(S_AXI_BVALID), 32'd0);
        check_val("same_rvalid_clr", 32'(S_AXI_RVALID), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'd0);
        check_val({tag, "_wready"},  32'(S_AXI_WREADY),  32'd0);
        check_val({tag, "_bvalid"},  32'(S_AXI_BVALID),  32'd0);
        check_val({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd0);
        check_val({tag, "_rvalid"},  32'(S_AXI_RVALID),  32'd0);
        check_val({tag, "_ttl"},     32'(TTL_OUT),       32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [31:0] pre;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          n;
        int          highs;

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;

        // Reset state
        check_idle_outputs("rst");
        check_val("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
        check_val("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
        check_val("rst_rdata", S_AXI_RDATA, 32'd0);
        ttl_chk = 1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d);
            check_val("rst_reg", d, 32'd0);
        end

        // Basic pulse train: PERIOD=10, WIDTH=3, EN
        axi_write(4'h4, 32'd10, 4'hF, 0, 0);
        axi_write(4'h8, 32'd3, 4'hF, 0, 0);
        axi_write(4'h0, 32'd1, 4'hF, 0, 0);
        repeat (96) @(negedge ACLK);
        axi_read(4'hC, d);
        check_val("count_after_100", 32'(d >= 32'd9 && d <= 32'd11), 32'd1);

        // Staggered VALIDs, delayed BREADY, partial strobe
        axi_write(4'h8, 32'd0, 4'hF, 0, 0);
        axi_write(4'h8, 32'hAABBCCDD, 4'b0010, 5, 4);
        axi_read(4'h8, d);
        check_val("width_strobed", d, 32'h0000CC00);

        // Write to COUNT with a same-cycle read of COUNT
        axi_wr_rd_same(4'hC, 32'hFFFFFFFF, pre);
        axi_read(4'hC, d);
        check_val("count_not_written", 32'(d != 32'hFFFFFFFF), 32'd1);

        // Shrink PERIOD while the count is high in the period
        axi_write(4'h8, 32'd3, 4'hF, 0, 0);
        n = 0;
        while (m_phase != 32'd6 && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check_val("phase_reached", 32'(n < 50), 32'd1);
        axi_write(4'h4, 32'd4, 4'hF, 0, 0);
        repeat (4) @(negedge ACLK);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            if (TTL_OUT) highs++;
        end
        check_val("period4_highs", 32'(highs), 32'd6);

        // INV with EN cleared holds the output high
        axi_write(4'h0, 32'd2, 4'hF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check_val("inv_hold", 32'(TTL_OUT), 32'd1);
            @(negedge ACLK);
        end

        // Reset with a response pending and the generator running
        axi_write(4'h0, 32'd1, 4'hF, 0, 0);
        repeat (3) @(negedge ACLK);
        axi_write(4'h8, 32'd2, 4'hF, 0, -1);
        check_val("pending_bvalid", 32'(S_AXI_BVALID), 32'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_idle_outputs("mid_rst");
        ARESET = 1'b0;
        @(negedge ACLK);
        check_val("post_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d);
            check_val("post_rst_reg", d, 32'd0);
        end

        // Randomized traffic
        repeat (60) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    addr = {2'($urandom_range(0, 3)), 2'($urandom)};
                    case (addr[3:2])
                        2'd0:    wdata = $urandom;
                        2'd1:    wdata = $urandom_range(0, 12);
                        2'd2:    wdata = $urandom_range(0, 14);
                        default: wdata = $urandom;
                    endcase
                    strb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                    axi_write(addr, wdata, strb, $urandom_range(0, 3), $urandom_range(0, 3));
                end
                2: axi_read({2'($urandom_range(0, 3)), 2'($urandom)}, d);
                default: repeat ($urandom_range(1, 20)) @(negedge ACLK);
            endcase
        end

        ttl_chk = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
